seq_det_sched: RTL and testbench

Round-robin scheduler that shares one "1101" non-overlapping Moore sequence-detector core between NCH serial input channels. Each channel's detector state is saved and restored on every context switch, so patterns that straddle grants are still detected. The block sits between the per-channel serial sources and the downstream match consumer.

---
 rtl/seq_det_sched.sv | 214 +++++++++++++++++++++
 tb/tb_seq_det_sched.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
// -----------------------------------------------------------------------------
// seq_det_sched
//
// Round-robin scheduler that time-shares one "1101" non-overlapping Moore
// sequence detector between NCH serial channels. Each channel's detector
// state lives in a context slot; it is loaded into the work register when the
// channel is granted and written back when the grant ends. A pattern that
// straddles two grants is therefore still detected.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req[i]     channel i presents a valid bit on din[i]
//   din[i]     serial bit of channel i, consumed when bit_ack[i]=1
//   gnt        one-hot owner of the detector (registered)
//   bit_ack    din[i] consumed this cycle (combinational)
//   busy       scheduler is not idle
//   det_valid  one-cycle pulse: a pattern completed
//   det_ch     channel that completed the pattern (valid with det_valid)
//
// Optional feature (macro SEQ_DET_SCHED_COUNT_EN):
//   cnt_sel    channel whose match counter is shown on cnt_out
//   cnt_out    saturating 8-bit match count of channel cnt_sel
// -----------------------------------------------------------------------------
module seq_det_sched #(
    parameter int NCH   = 4,
    parameter int BURST = 8,
    parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] req,
    input  logic [NCH-1:0] din,
`ifdef SEQ_DET_SCHED_COUNT_EN
    input  logic [CW-1:0]  cnt_sel,
    output logic [7:0]     cnt_out,
`endif
    output logic [NCH-1:0] gnt,
    output logic [NCH-1:0] bit_ack,
    output logic           busy,
    output logic           det_valid,
    output logic [CW-1:0]  det_ch
);

    localparam int CNTW = $clog2(BURST + 1);

    // Scheduler states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SAVE = 2'd2;

    // Detector states
    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b010;
    localparam logic [2:0] S3 = 3'b011;
    localparam logic [2:0] S4 = 3'b100;

    logic [1:0]      state_q, state_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [CW-1:0]   owner_q, owner_d;
    logic [2:0]      work_q, work_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CW-1:0]   ptr_q, ptr_d;
    logic [2:0]      ctx_q [NCH];
    logic [2:0]      ctx_d [NCH];
    logic            det_valid_q, det_valid_d;
    logic [CW-1:0]   det_ch_q, det_ch_d;

    logic            pick_found;
    logic [CW-1:0]   pick_idx;
    logic [CW-1:0]   cand;

    // S4 leaves on the S0 row (non-overlapping): a resumed S4 context
    // never re-enters S4 on its next bit.
    function automatic logic [2:0] det_next(input logic [2:0] s, input logic b);
        case (s)
            S0:      det_next = b ? S1 : S0;
            S1:      det_next = b ? S2 : S0;
            S2:      det_next = b ? S2 : S3;
            S3:      det_next = b ? S4 : S0;
            S4:      det_next = b ? S1 : S0;
            default: det_next = S0;
        endcase
    endfunction

    // First requesting channel at or after ptr, wrapping around.
    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment,
        // so no path leaves it unassigned and no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 0; k < NCH; k++) begin
            cand = CW'((int'(ptr_q) + k) % NCH);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        work_d      = work_q;
        count_d     = count_q;
        ptr_d       = ptr_q;
        ctx_d       = ctx_q;
        det_valid_d = 1'b0;
        det_ch_d    = det_ch_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    owner_d         = pick_idx;
                    work_d          = ctx_q[pick_idx];
                    count_d         = '0;
                    state_d         = ST_RUN;
                end
            end
            ST_RUN: begin
                if (req[owner_q]) begin
                    work_d  = det_next(work_q, din[owner_q]);
                    count_d = count_q + 1'b1;
                    if (work_d == S4) begin
                        det_valid_d = 1'b1;
                        det_ch_d    = owner_q;
                    end
                    if (count_q == CNTW'(BURST - 1)) begin
                        gnt_d   = '0;
                        state_d = ST_SAVE;
                    end
                end else begin
                    // Owner ran dry: release early rather than idle the core.
                    gnt_d   = '0;
                    state_d = ST_SAVE;
                end
            end
            ST_SAVE: begin
                ctx_d[owner_q] = work_q;
                ptr_d          = (int'(owner_q) == NCH - 1) ? '0 : owner_q + 1'b1;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            work_q      <= S0;
            count_q     <= '0;
            ptr_q       <= '0;
            det_valid_q <= 1'b0;
            det_ch_q    <= '0;
            // NOTE: the context array is reset on purpose; a channel must not
            // resume from a partial pattern left over from before reset.
            for (int i = 0; i < NCH; i++) begin
                ctx_q[i] <= S0;
            end
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed by the combinational blocks.
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            work_q      <= work_d;
            count_q     <= count_d;
            ptr_q       <= ptr_d;
            ctx_q       <= ctx_d;
            det_valid_q <= det_valid_d;
            det_ch_q    <= det_ch_d;
        end
    end

    // gnt is one-hot on the owner throughout RUN, so masking req with it
    // acknowledges exactly the owner's bit.
    assign bit_ack   = (state_q == ST_RUN) ? (gnt_q & req) : '0;
    assign gnt       = gnt_q;
    assign busy      = (state_q != ST_IDLE);
    assign det_valid = det_valid_q;
    assign det_ch    = det_ch_q;

`ifdef SEQ_DET_SCHED_COUNT_EN
    logic [7:0] match_cnt_q [NCH];
    logic [7:0] match_cnt_d [NCH];

    always_comb begin
        match_cnt_d = match_cnt_q;
        if (det_valid_q && (match_cnt_q[det_ch_q] != 8'hFF)) begin
            match_cnt_d[det_ch_q] = match_cnt_q[det_ch_q] + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                match_cnt_q[i] <= 8'd0;
            end
        end else begin
            match_cnt_q <= match_cnt_d;
        end
    end

    assign cnt_out = (int'(cnt_sel) < NCH) ? match_cnt_q[cnt_sel] : 8'd0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
module tb_seq_det_sched;

    localparam int NCH   = 4;
    localparam int BURST = 8;
    localparam int CW    = 2;
    localparam int DEPTH = 2048;

    logic           clk = 1'b0;
    logic           reset;
    logic [NCH-1:0] req;
    logic [NCH-1:0] din;
    logic [NCH-1:0] gnt;
    logic [NCH-1:0] bit_ack;
    logic           busy;
    logic           det_valid;
    logic [CW-1:0]  det_ch;
`ifdef SEQ_DET_SCHED_COUNT_EN
    logic [CW-1:0]  cnt_sel;
    logic [7:0]     cnt_out;
`endif

    seq_det_sched #(.NCH(NCH), .BURST(BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .din       (din),
`ifdef SEQ_DET_SCHED_COUNT_EN
        .cnt_sel   (cnt_sel),
        .cnt_out   (cnt_out),
`endif
        .gnt       (gnt),
        .bit_ack   (bit_ack),
        .busy      (busy),
        .det_valid (det_valid),
        .det_ch    (det_ch)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: channel and the sample cycle det_valid must appear on.
    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    // Per-channel bit sources (FIFO of pending bits).
    bit src_mem [NCH][DEPTH];
    int src_rd  [NCH];
    int src_wr  [NCH];

    // Reference model: last four bits and bits seen since the last match.
    logic [3:0] m_hist  [NCH];
    int         m_since [NCH];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int det_seen = 0;

    logic [NCH-1:0] s_gnt;
    logic [NCH-1:0] s_ack;
    logic           s_busy;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_inputs();
        for (int i = 0; i < NCH; i++) begin
            req[i] = (src_rd[i] != src_wr[i]);
            din[i] = req[i] ? src_mem[i][src_rd[i]] : 1'b0;
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < NCH; i++) begin
            src_rd[i]  = 0;
            src_wr[i]  = 0;
            m_hist[i]  = 4'b0000;
            m_since[i] = 0;
        end
        exp_q.delete();
    endtask

    // Append n bits, first bit = bits[n-1].
    task automatic push_bits(input int ch, input logic [31:0] bits, input int n);
        if (src_rd[ch] == src_wr[ch]) begin
            src_rd[ch] = 0;
            src_wr[ch] = 0;
        end
        for (int j = 0; j < n; j++) begin
            src_mem[ch][src_wr[ch]] = bits[n-1-j];
            src_wr[ch]++;
        end
        drive_inputs();
    endtask

    task automatic model_step(input int ch, input logic b, output logic hit);
        m_hist[ch] = {m_hist[ch][2:0], b};
        m_since[ch]++;
        hit = 1'b0;
        if (m_since[ch] >= 4 && m_hist[ch] == 4'b1101) begin
            hit         = 1'b1;
            m_since[ch] = 0;
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (src_rd[i] != src_wr[i]) p = 1'b1;
        end
        return p;
    endfunction

    // One clock: sample at negedge, score detections, account consumed bits,
    // then present the next bits just after the rising edge.
    task automatic step();
        logic [NCH-1:0] consumed;
        logic hit;
        exp_t e;
        consumed = '0;
        @(negedge clk);
        cyc++;
        s_gnt  = gnt;
        s_ack  = bit_ack;
        s_busy = busy;

        if (det_valid === 1'b1) begin
            det_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL det_unexpected: det_valid=1 det_ch=%0d at cycle %0d, required no pulse", det_ch, cyc);
            end else begin
                e = exp_q.pop_front();
                if (det_ch !== CW'(e.ch) || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL det_match: got ch %0d at cycle %0d, required ch %0d at cycle %0d",
                             det_ch, cyc, e.ch, e.cyc);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL det_missing: det_valid=%b at cycle %0d, required pulse for ch %0d", det_valid, cyc, e.ch);
        end

        checks++;
        if ((bit_ack & ~(req & gnt)) !== '0) begin
            errors++;
            $display("FAIL ack_illegal: bit_ack=%b req=%b gnt=%b, required ack only on requesting owner",
                     bit_ack, req, gnt);
        end

        for (int i = 0; i < NCH; i++) begin
            if (bit_ack[i] === 1'b1) begin
                consumed[i] = 1'b1;
                model_step(i, din[i], hit);
                if (hit) exp_q.push_back('{i, cyc + 1});
            end
        end

        @(posedge clk);
        #1;
        for (int i = 0; i < NCH; i++) begin
            if (consumed[i]) src_rd[i]++;
        end
        drive_inputs();
    endtask

    task automatic run_idle(input string name, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while ((pending() || s_busy || exp_q.size() != 0) && n < budget);
        if (pending() || s_busy || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, budget);
            exp_q.delete();
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        clear_all();
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_all();
        req = '1;
        din = '1;
        #1;
        checks++;
        if (gnt !== '0 || bit_ack !== '0 || busy !== 1'b0 || det_valid !== 1'b0 || det_ch !== '0) begin
            errors++;
            $display("FAIL reset_values: gnt=%b bit_ack=%b busy=%b det_valid=%b det_ch=%0d, required all 0",
                     gnt, bit_ack, busy, det_valid, det_ch);
        end
        @(posedge clk);
        #1;
        checks++;
        if (gnt !== '0 || bit_ack !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: gnt=%b bit_ack=%b busy=%b with req high in reset, required 0",
                     gnt, bit_ack, busy);
        end
        @(negedge clk);
        reset = 1'b1;
        drive_inputs();
    endtask

    task automatic test_fairness();
        logic [NCH-1:0] grants[$];
        logic [NCH-1:0] prev = '0;
        logic [NCH-1:0] exp_seq [5];
        int gap = 0;
        int acks = 0;
        int n = 0;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < NCH; i++) begin
            push_bits(i, 32'($urandom_range(0, 65535)), 16);
        end
        do begin
            step();
            n++;
            if (s_gnt != '0) begin
                if (prev == '0) begin
                    grants.push_back(s_gnt);
                    if (grants.size() > 1) begin
                        checks++;
                        if (gap != 2) begin
                            errors++;
                            $display("FAIL fair_gap: %0d idle cycles before grant %b, required 2", gap, s_gnt);
                        end
                    end
                    acks = 0;
                end
                if (s_ack != '0) acks++;
            end else begin
                if (prev != '0) begin
                    checks++;
                    if (acks != BURST) begin
                        errors++;
                        $display("FAIL fair_acks: grant %b gave %0d bit_acks, required %0d", prev, acks, BURST);
                    end
                    gap = 0;
                end
                gap++;
            end
            prev = s_gnt;
        end while ((pending() || s_busy || exp_q.size() != 0) && n < 400);
        checks++;
        if (grants.size() != 8) begin
            errors++;
            $display("FAIL fair_count: %0d grants, required 8", grants.size());
        end
        for (int k = 0; k < 5 && k < grants.size(); k++) begin
            checks++;
            if (grants[k] !== exp_seq[k]) begin
                errors++;
                $display("FAIL fair_order: grant %0d was %b, required %b", k, grants[k], exp_seq[k]);
            end
        end
    endtask

    task automatic test_single();
        int d0 = det_seen;
        push_bits(0, 32'b1101, 4);
        step();
        checks++;
        if (s_gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_pre_gnt: gnt=%b before req is seen, required 0000", s_gnt);
        end
        step();
        checks++;
        if (s_gnt !== 4'b0001 || s_ack !== 4'b0001) begin
            errors++;
            $display("FAIL single_gnt: gnt=%b bit_ack=%b, required 0001/0001", s_gnt, s_ack);
        end
        run_idle("single", 50);
        checks++;
        if (det_seen - d0 != 1) begin
            errors++;
            $display("FAIL single_count: %0d detections, required 1", det_seen - d0);
        end
    endtask

    task automatic test_context();
        int d0 = det_seen;
        push_bits(0, 32'b11, 2);
        run_idle("ctx_a", 50);
        push_bits(1, 32'b00, 2);
        run_idle("ctx_b", 50);
        push_bits(0, 32'b01, 2);
        run_idle("ctx_c", 50);
        checks++;
        if (det_seen - d0 != 1) begin
            errors++;
            $display("FAIL ctx_count: %0d detections, required 1", det_seen - d0);
        end
    endtask

    task automatic test_non_overlap();
        int d0 = det_seen;
        push_bits(2, 32'b1101101, 7);
        run_idle("novl_a", 50);
        checks++;
        if (det_seen - d0 != 1) begin
            errors++;
            $display("FAIL novl_first: %0d detections, required 1", det_seen - d0);
        end
        push_bits(2, 32'b1101, 4);
        run_idle("novl_b", 50);
        checks++;
        if (det_seen - d0 != 2) begin
            errors++;
            $display("FAIL novl_second: %0d detections, required 2", det_seen - d0);
        end
    endtask

    task automatic test_reset_mid_burst();
        int d0;
        int n = 0;
        push_bits(1, 32'b1101, 4);
        while (src_rd[1] < 3 && n < 50) begin
            step();
            n++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (gnt !== '0 || busy !== 1'b0 || det_valid !== 1'b0 || bit_ack !== '0) begin
            errors++;
            $display("FAIL midrst_values: gnt=%b busy=%b det_valid=%b bit_ack=%b, required all 0",
                     gnt, busy, det_valid, bit_ack);
        end
        clear_all();
        drive_inputs();
        @(negedge clk);
        reset = 1'b1;
        d0 = det_seen;
        push_bits(1, 32'b1, 1);
        run_idle("midrst", 50);
        checks++;
        if (det_seen - d0 != 0) begin
            errors++;
            $display("FAIL midrst_ctx: %0d detections after reset, required 0", det_seen - d0);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        apply_reset();
        d0 = det_seen;
        for (int p = 0; p < 300; p++) begin
            push_bits(3, 32'b1101, 4);
        end
        run_idle("b2b", 3000);
        checks++;
        if (det_seen - d0 != 300) begin
            errors++;
            $display("FAIL b2b_count: %0d detections, required 300", det_seen - d0);
        end
`ifdef SEQ_DET_SCHED_COUNT_EN
        for (int c = 0; c < NCH; c++) begin
            cnt_sel = CW'(c);
            #1;
            checks++;
            if (cnt_out !== ((c == 3) ? 8'd255 : 8'd0)) begin
                errors++;
                $display("FAIL cnt_out: cnt_sel=%0d cnt_out=%0d, required %0d", c, cnt_out,
                         (c == 3) ? 255 : 0);
            end
        end
`endif
    endtask

    initial begin
`ifdef SEQ_DET_SCHED_COUNT_EN
        cnt_sel = '0;
`endif
        req   = '0;
        din   = '0;
        reset = 1'b1;
        test_reset();
        test_fairness();
        test_single();
        test_context();
        test_non_overlap();
        test_reset_mid_burst();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
